wb_write_queue: RTL
===================

# wb_write_queue

Writeback write-port driver for the CPU register bank. Accepts completed results from the ALU and the memory (load) path, buffers them in a small in-order queue, and drains one entry per cycle into the bank's single write port (`writeReg`, `writeData`, `regWrite`). Provides two bypass lookups so decode can read results that are still queued and not yet written into the bank. Drops writes to the zero register.

## Interface
- `DATA_W`, 64: result width.
- `ADDR_W`, 5: register index width.
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `ZERO_REG`, 31: index whose writes are discarded (XZR).

- `clk` in 1: single clock; all state updates on the posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_rd` in ADDR_W: ALU destination register.
- `alu_data` in DATA_W: ALU result.
- `mem_valid` in 1: load result present this cycle.
- `mem_rd` in ADDR_W: load destination register.
- `mem_data` in DATA_W: load data.
- `in_ready` out 1: room for two enqueues this cycle.
- `writeReg` out ADDR_W: register bank write index (registered).
- `writeData` out DATA_W: register bank write data (registered).
- `regWrite` out 1: register bank write enable (registered).
- `byp_addr1`, `byp_addr2` in ADDR_W: decode read indices.
- `byp_hit1`, `byp_hit2` out 1: a pending write to that index exists.
- `byp_data1`, `byp_data2` out DATA_W: youngest pending data for that index; 0 when there is no hit.
- `occupancy` out $clog2(DEPTH)+1: queued entries, excluding the output stage.
- `ovf` out 1: sticky overflow flag.

## Operation
- Enqueue: a valid source is enqueued only when `in_ready`=1 and its rd ≠ ZERO_REG. A source with rd = ZERO_REG is consumed silently.
- Same-cycle ALU and mem: ALU is enqueued first (older), mem second (younger). Both may target the same rd; mem's value is the final one.
- `in_ready` = (`occupancy` ≤ DEPTH−2). It depends only on registered state, never on the valids.
- Overflow: any valid non-ZERO_REG source while `in_ready`=0 is dropped and sets `ovf`=1. `ovf` is cleared only by reset.
- Drain: at each posedge with `occupancy`>0, the head moves into the output stage (`writeReg`/`writeData`) and `regWrite`=1. Otherwise `regWrite`=0, and `writeReg`/`writeData` hold their last values.
- Enqueue and drain in the same cycle: `occupancy` changes by (enqueued − 1).
- Bypass search covers all queue entries plus the output stage while `regWrite`=1. The youngest match wins, in this order: newest queue entry, older entries, then the output stage. An address of ZERO_REG always gives hit=0. The bypass path is combinational.
- Pointer wrap: head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full vs empty is taken from `occupancy`.

## Timing
- Reset values: `regWrite`=0, `writeReg`=0, `writeData`=0, `occupancy`=0, `ovf`=0, pointers=0; `in_ready`=1 and bypass hits=0 follow from this state. Reset asserted mid-operation discards all pending entries immediately.
- Enqueue-to-write latency on an empty queue:
  - enqueue at edge N;
  - pop to output stage at edge N+1; `regWrite`=1 during cycle N+1;
  - bank commits at edge N+2.
- Bypass visibility: from just after edge N until the bank commits at edge N+2. There is no window in which the value is in neither the queue nor the bank.
- Throughput: one bank write per cycle; sustained input of two per cycle fills the queue.

## Structure
- Shared `cpu_pkg` holds: `REG_ADDR_W`, `DATA_W`, `XZR_IDX`=31, and the `wb_entry_t` struct {rd, data}.
- One sub-module, `wb_bypass_match`: the youngest-match priority search over entries plus output stage, instantiated twice (ports 1 and 2).

## Test plan
- **Single write.** Reset; ALU writes rd=3, data=0xAA at edge 0.
  - `regWrite`=1, `writeReg`=3, `writeData`=0xAA during cycle 1.
  - `byp_hit1`=1 for address 3 from cycle 0 through cycle 1.
- **Same-cycle same rd.** ALU rd=5, 0x11 and mem rd=5, 0x22 in the same cycle.
  - Two consecutive writes: 0x11, then 0x22.
  - Bypass on address 5 returns 0x22 until the second write commits.
- **Zero register.** ALU rd=31, 0xFF.
  - `occupancy` stays 0, `regWrite` stays 0.
  - Bypass on address 31 gives hit=0.
- **Fill and overflow.** Both sources valid for 3 cycles with DEPTH=4.
  - `in_ready` falls once `occupancy`=3.
  - The third-cycle inputs are dropped and `ovf`=1.
  - Exactly 4 writes emerge in order.
- **Reset mid-drain.** Queue holds 3 entries; assert `rst_n`=0 asynchronously between edges.
  - Outputs go to reset values at once; no further `regWrite` pulses after release.
- **Pointer wrap.** 10 alternating single enqueues into rd=1..10 with values rd×0x10.
  - Writes appear in order with correct data across the pointer wrap.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-bank geometry and the writeback entry
// layout used by the writeback queue and its consumers.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 64;
   localparam int XZR_IDX    = 31;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-match search over the pending writeback entries plus the output
// stage. Entries arrive ordered oldest (index 0) to youngest (index DEPTH-1);
// the output stage is older than every queued entry.
module wb_bypass_match #(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int ADDR_W   = cpu_pkg::REG_ADDR_W,
   parameter int DEPTH    = 4,
   parameter int ZERO_REG = cpu_pkg::XZR_IDX
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DEPTH-1:0]  entValid,
   input  logic [ADDR_W-1:0] entRd   [DEPTH],
   input  logic [DATA_W-1:0] entData [DEPTH],
   input  logic              outValid,
   input  logic [ADDR_W-1:0] outRd,
   input  logic [DATA_W-1:0] outData,
   output logic              hit,
   output logic [DATA_W-1:0] data
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   // Scan oldest to youngest so that later (younger) matches overwrite
   // earlier ones; the zero register never produces a hit.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      if (addr != ZERO_IDX) begin
         if (outValid && (outRd == addr)) begin
            hit  = 1'b1;
            data = outData;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (entValid[i] && (entRd[i] == addr)) begin
               hit  = 1'b1;
               data = entData[i];
            end
         end
      end
   end

endmodule

// File: rtl/wb_write_queue.sv
// Writeback write-port driver: buffers ALU and load results in an in-order
// queue, drains one per cycle into the register bank write port, and exposes
// two combinational bypass lookups over everything not yet committed.
module wb_write_queue
   import cpu_pkg::*;
#(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int ADDR_W   = cpu_pkg::REG_ADDR_W,
   parameter int DEPTH    = 4,
   parameter int ZERO_REG = XZR_IDX
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alu_valid,
   input  logic [ADDR_W-1:0]          alu_rd,
   input  logic [DATA_W-1:0]          alu_data,
   input  logic                       mem_valid,
   input  logic [ADDR_W-1:0]          mem_rd,
   input  logic [DATA_W-1:0]          mem_data,
   output logic                       in_ready,
   output logic [ADDR_W-1:0]          writeReg,
   output logic [DATA_W-1:0]          writeData,
   output logic                       regWrite,
   input  logic [ADDR_W-1:0]          byp_addr1,
   input  logic [ADDR_W-1:0]          byp_addr2,
   output logic                       byp_hit1,
   output logic                       byp_hit2,
   output logic [DATA_W-1:0]          byp_data1,
   output logic [DATA_W-1:0]          byp_data2,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic                       ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);
   localparam logic [OCC_W-1:0]  READY_MAX = OCC_W'(DEPTH - 2);

   logic [ADDR_W-1:0] qRd   [DEPTH];
   logic [DATA_W-1:0] qData [DEPTH];
   logic [PTR_W-1:0]  headPtr;
   logic [PTR_W-1:0]  tailPtr;
   logic [OCC_W-1:0]  occCnt;

   logic              aluLive;
   logic              memLive;
   logic              aluEn;
   logic              memEn;
   logic              doPop;
   logic [PTR_W-1:0]  memSlot;

   logic [DEPTH-1:0]  ordValid;
   logic [ADDR_W-1:0] ordRd   [DEPTH];
   logic [DATA_W-1:0] ordData [DEPTH];

   // Readiness is purely a function of registered occupancy so that upstream
   // never sees a combinational loop through the valids.
   assign in_ready  = (occCnt <= READY_MAX);
   assign occupancy = occCnt;

   assign aluLive = alu_valid && (alu_rd != ZERO_IDX);
   assign memLive = mem_valid && (mem_rd != ZERO_IDX);
   assign aluEn   = aluLive && in_ready;
   assign memEn   = memLive && in_ready;
   assign doPop   = (occCnt != '0);
   // The load result lands behind the ALU result when both are enqueued.
   assign memSlot = tailPtr + PTR_W'(aluEn);

   // Queue storage; contents of empty slots are never observed, so no reset.
   always_ff @(posedge clk) begin
      if (aluEn) begin
         qRd[tailPtr]   <= alu_rd;
         qData[tailPtr] <= alu_data;
      end
      if (memEn) begin
         qRd[memSlot]   <= mem_rd;
         qData[memSlot] <= mem_data;
      end
   end

   // Pointers, occupancy, output stage and the sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         headPtr   <= '0;
         tailPtr   <= '0;
         occCnt    <= '0;
         ovf       <= 1'b0;
         regWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else begin
         if (doPop) begin
            writeReg  <= qRd[headPtr];
            writeData <= qData[headPtr];
            headPtr   <= headPtr + PTR_W'(1);
            regWrite  <= 1'b1;
         end else begin
            regWrite  <= 1'b0;
         end
         tailPtr <= tailPtr + PTR_W'(aluEn) + PTR_W'(memEn);
         occCnt  <= occCnt + OCC_W'(aluEn) + OCC_W'(memEn) - OCC_W'(doPop);
         if ((aluLive || memLive) && !in_ready) begin
            ovf <= 1'b1;
         end
      end
   end

   // Present the queue to the bypass search in age order, oldest first.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ordValid[i] = (OCC_W'(i) < occCnt);
         ordRd[i]    = qRd[headPtr + PTR_W'(i)];
         ordData[i]  = qData[headPtr + PTR_W'(i)];
      end
   end

   wb_bypass_match #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_byp1 (
      .addr     (byp_addr1),
      .entValid (ordValid),
      .entRd    (ordRd),
      .entData  (ordData),
      .outValid (regWrite),
      .outRd    (writeReg),
      .outData  (writeData),
      .hit      (byp_hit1),
      .data     (byp_data1)
   );

   wb_bypass_match #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_byp2 (
      .addr     (byp_addr2),
      .entValid (ordValid),
      .entRd    (ordRd),
      .entData  (ordData),
      .outValid (regWrite),
      .outRd    (writeReg),
      .outData  (writeData),
      .hit      (byp_hit2),
      .data     (byp_data2)
   );

endmodule
